// File: rtl/channel_acq_arbiter_pkg.sv
// Shared definitions for the acquisition-line arbiter: one-hot state encoding and bus widths.
package channel_acq_arbiter_pkg;

    localparam int unsigned ST_IDLE_BIT  = 0;
    localparam int unsigned ST_SYNC_BIT  = 1;
    localparam int unsigned ST_GUARD_BIT = 2;
    localparam int unsigned ST_ASYNC_BIT = 3;

    localparam int unsigned ACQ_EN_W   = 10;
    localparam int unsigned ACQ_TRIG_W = 5;
    localparam int unsigned FIFO_W     = 32;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_SYNC  = 4'b0010,
        ST_GUARD = 4'b0100,
        ST_ASYNC = 4'b1000
    } arb_state_t;

endpackage

// File: rtl/channel_acq_arbiter_guard.sv
// Guard-gap counter: counts while enabled and flags the cycle whose count reaches GUARD_CYCLES.
module acq_guard_counter #(
    parameter int unsigned GUARD_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_count,
    output logic o_done
);

    localparam logic [4:0] LP_LAST = 5'(GUARD_CYCLES);

    logic [3:0] r_count;
    logic [4:0] w_next_count;
    logic       w_done;

    assign w_next_count = {1'b0, r_count} + 5'd1;
    assign w_done       = i_count && (w_next_count == LP_LAST);
    assign o_done       = w_done;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_load) begin
            r_count <= '0;
        end else if (i_count) begin
            r_count <= w_done ? '0 : w_next_count[3:0];
        end
    end

endmodule

// File: rtl/channel_acq_arbiter.sv
// Hands the channel acquisition lines and event-FIFO write port to either the sync or async controller.
module channel_acq_arbiter
    import channel_acq_arbiter_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  async_mode,
    input  logic                  sync_idle,
    input  logic [ACQ_EN_W-1:0]   sync_acq_enable,
    input  logic [ACQ_TRIG_W-1:0] sync_acq_trig,
    input  logic                  sync_fifo_valid,
    input  logic [FIFO_W-1:0]     sync_fifo_data,
    output logic                  sync_fifo_ready,
    output logic                  sync_grant,
    input  logic                  async_idle,
    input  logic [ACQ_EN_W-1:0]   async_acq_enable,
    input  logic [ACQ_TRIG_W-1:0] async_acq_trig,
    input  logic                  async_fifo_valid,
    input  logic [FIFO_W-1:0]     async_fifo_data,
    output logic                  async_fifo_ready,
    output logic                  async_grant,
    output logic [ACQ_EN_W-1:0]   acq_enable,
    output logic [ACQ_TRIG_W-1:0] acq_trig,
    output logic                  fifo_valid,
    output logic [FIFO_W-1:0]     fifo_data,
    input  logic                  fifo_ready,
    input  logic                  clear_err,
    output logic                  conflict_err,
    output logic [3:0]            state
);

    arb_state_t              r_state;
    arb_state_t              w_next;
    logic [ACQ_EN_W-1:0]     r_acq_enable;
    logic [ACQ_TRIG_W-1:0]   r_acq_trig;
    logic                    r_conflict;
    logic                    w_sync_grant;
    logic                    w_async_grant;
    logic                    w_in_guard;
    logic                    w_guard_done;
    logic                    w_pass_sync;
    logic                    w_pass_async;
    logic                    w_conflict;

    assign w_sync_grant  = r_state[ST_SYNC_BIT];
    assign w_async_grant = r_state[ST_ASYNC_BIT];
    assign w_in_guard    = r_state[ST_GUARD_BIT];

    acq_guard_counter #(
        .GUARD_CYCLES(GUARD_CYCLES)
    ) u_guard (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_load  (!w_in_guard),
        .i_count (w_in_guard),
        .o_done  (w_guard_done)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  w_next = async_mode ? ST_ASYNC : ST_SYNC;
            ST_SYNC:  if (async_mode && sync_idle && !sync_fifo_valid) w_next = ST_GUARD;
            ST_ASYNC: if (!async_mode && async_idle && !async_fifo_valid) w_next = ST_GUARD;
            ST_GUARD: if (w_guard_done) w_next = async_mode ? ST_ASYNC : ST_SYNC;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Lines only follow an owner that keeps the grant, so they are low for the whole guard gap.
    assign w_pass_sync  = w_sync_grant  && (w_next == ST_SYNC);
    assign w_pass_async = w_async_grant && (w_next == ST_ASYNC);

    assign w_conflict = (!w_sync_grant  && ((|sync_acq_trig)  || sync_fifo_valid))
                     || (!w_async_grant && ((|async_acq_trig) || async_fifo_valid));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_acq_enable <= '0;
            r_acq_trig   <= '0;
            r_conflict   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_pass_sync) begin
                r_acq_enable <= sync_acq_enable;
                r_acq_trig   <= sync_acq_trig;
            end else if (w_pass_async) begin
                r_acq_enable <= async_acq_enable;
                r_acq_trig   <= async_acq_trig;
            end else begin
                r_acq_enable <= '0;
                r_acq_trig   <= '0;
            end
            if (w_conflict) begin
                r_conflict <= 1'b1;
            end else if (clear_err) begin
                r_conflict <= 1'b0;
            end
        end
    end

    assign sync_grant       = w_sync_grant;
    assign async_grant      = w_async_grant;
    assign acq_enable       = r_acq_enable;
    assign acq_trig         = r_acq_trig;
    assign conflict_err     = r_conflict;
    assign state            = r_state;

    assign fifo_valid       = (w_sync_grant && sync_fifo_valid) || (w_async_grant && async_fifo_valid);
    assign fifo_data        = w_sync_grant  ? sync_fifo_data
                            : w_async_grant ? async_fifo_data : '0;
    assign sync_fifo_ready  = w_sync_grant  && fifo_ready;
    assign async_fifo_ready = w_async_grant && fifo_ready;

endmodule

// File: tb/tb_channel_acq_arbiter.sv
// Directed-vector bench for channel_acq_arbiter: reset, passthrough, handover, FIFO routing, conflict flag.
`timescale 1ns/1ps
module tb_channel_acq_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        async_mode;
    logic        sync_idle;
    logic [9:0]  sync_acq_enable;
    logic [4:0]  sync_acq_trig;
    logic        sync_fifo_valid;
    logic [31:0] sync_fifo_data;
    logic        sync_fifo_ready;
    logic        sync_grant;
    logic        async_idle;
    logic [9:0]  async_acq_enable;
    logic [4:0]  async_acq_trig;
    logic        async_fifo_valid;
    logic [31:0] async_fifo_data;
    logic        async_fifo_ready;
    logic        async_grant;
    logic [9:0]  acq_enable;
    logic [4:0]  acq_trig;
    logic        fifo_valid;
    logic [31:0] fifo_data;
    logic        fifo_ready;
    logic        clear_err;
    logic        conflict_err;
    logic [3:0]  state;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #12 clk = ~clk;

    channel_acq_arbiter #(.GUARD_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .async_mode(async_mode),
        .sync_idle(sync_idle), .sync_acq_enable(sync_acq_enable), .sync_acq_trig(sync_acq_trig),
        .sync_fifo_valid(sync_fifo_valid), .sync_fifo_data(sync_fifo_data),
        .sync_fifo_ready(sync_fifo_ready), .sync_grant(sync_grant),
        .async_idle(async_idle), .async_acq_enable(async_acq_enable), .async_acq_trig(async_acq_trig),
        .async_fifo_valid(async_fifo_valid), .async_fifo_data(async_fifo_data),
        .async_fifo_ready(async_fifo_ready), .async_grant(async_grant),
        .acq_enable(acq_enable), .acq_trig(acq_trig), .fifo_valid(fifo_valid),
        .fifo_data(fifo_data), .fifo_ready(fifo_ready), .clear_err(clear_err),
        .conflict_err(conflict_err), .state(state)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic all_inputs(input logic v);
        async_mode       = v;
        sync_idle        = v;
        sync_acq_enable  = {10{v}};
        sync_acq_trig    = {5{v}};
        sync_fifo_valid  = v;
        sync_fifo_data   = {32{v}};
        async_idle       = v;
        async_acq_enable = {10{v}};
        async_acq_trig   = {5{v}};
        async_fifo_valid = v;
        async_fifo_data  = {32{v}};
        fifo_ready       = v;
        clear_err        = v;
    endtask

    initial begin
        // reset with every input high
        reset_n = 1'b0;
        all_inputs(1'b1);
        repeat (3) tick();
        check_val("rst_state", 32'(state), 32'h1);
        check_val("rst_grants", {30'b0, sync_grant, async_grant}, 32'h0);
        check_val("rst_en", 32'(acq_enable), 32'h0);
        check_val("rst_trig", 32'(acq_trig), 32'h0);
        check_val("rst_fvalid", 32'(fifo_valid), 32'h0);
        check_val("rst_fdata", fifo_data, 32'h0);
        check_val("rst_fready", {30'b0, sync_fifo_ready, async_fifo_ready}, 32'h0);
        check_val("rst_err", 32'(conflict_err), 32'h0);

        all_inputs(1'b0);
        reset_n = 1'b1;
        tick();
        check_val("idle_to_sync", 32'(state), 32'h2);
        check_val("sync_grant", 32'(sync_grant), 32'h1);

        // passthrough, async inputs ignored
        sync_acq_trig    = 5'b10101;
        sync_acq_enable  = 10'h3FF;
        async_acq_enable = 10'h2AA;
        #1;
        check_val("pt_before", 32'(acq_trig), 32'h0);
        tick();
        check_val("pt_trig", 32'(acq_trig), 32'h15);
        check_val("pt_en", 32'(acq_enable), 32'h3FF);
        sync_acq_trig   = 5'b0;
        sync_acq_enable = 10'h155;
        tick();
        check_val("pt_trig2", 32'(acq_trig), 32'h0);
        check_val("pt_en2", 32'(acq_enable), 32'h155);

        // handover blocked while sync busy
        async_mode = 1'b1;
        sync_idle  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("ho_hold", 32'(state), 32'h2);
        end
        sync_idle = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check_val("guard_state", 32'(state), 32'h4);
            check_val("guard_en", 32'(acq_enable), 32'h0);
            check_val("guard_grant", {30'b0, sync_grant, async_grant}, 32'h0);
            tick();
        end
        check_val("to_async", 32'(state), 32'h8);
        check_val("async_grant", 32'(async_grant), 32'h1);
        sync_idle       = 1'b0;
        sync_acq_enable = 10'h0;

        // FIFO routing to async owner
        async_fifo_valid = 1'b1;
        async_fifo_data  = 32'h0A00_0123;
        fifo_ready       = 1'b0;
        #1;
        check_val("f_valid", 32'(fifo_valid), 32'h1);
        check_val("f_data", fifo_data, 32'h0A00_0123);
        for (int i = 0; i < 3; i++) begin
            check_val("f_aready0", 32'(async_fifo_ready), 32'h0);
            tick();
        end
        fifo_ready = 1'b1;
        #1;
        check_val("f_aready1", 32'(async_fifo_ready), 32'h1);
        check_val("f_sready", 32'(sync_fifo_ready), 32'h0);

        // switch blocked by pending word
        async_mode = 1'b0;
        async_idle = 1'b1;
        fifo_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("pend_hold", 32'(state), 32'h8);
        end
        fifo_ready = 1'b1;
        tick();
        check_val("pend_accept", 32'(state), 32'h8);
        async_fifo_valid = 1'b0;
        fifo_ready       = 1'b0;
        tick();
        check_val("pend_guard", 32'(state), 32'h4);
        repeat (4) tick();
        check_val("back_sync", 32'(state), 32'h2);
        check_val("no_err", 32'(conflict_err), 32'h0);

        // conflict flag: set, hold, clear, set-wins
        async_acq_trig = 5'b00001;
        tick();
        async_acq_trig = 5'b0;
        check_val("cf_set", 32'(conflict_err), 32'h1);
        tick();
        check_val("cf_hold", 32'(conflict_err), 32'h1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check_val("cf_clr", 32'(conflict_err), 32'h0);
        async_acq_trig = 5'b00001;
        clear_err      = 1'b1;
        tick();
        async_acq_trig = 5'b0;
        check_val("cf_setwins", 32'(conflict_err), 32'h1);
        tick();
        clear_err = 1'b0;
        check_val("cf_clr2", 32'(conflict_err), 32'h0);

        // reset mid-operation drops the lines
        sync_acq_enable = 10'h3FF;
        repeat (2) tick();
        check_val("mid_en", 32'(acq_enable), 32'h3FF);
        reset_n = 1'b0;
        tick();
        check_val("mid_rst_en", 32'(acq_enable), 32'h0);
        check_val("mid_rst_state", 32'(state), 32'h1);
        check_val("mid_rst_grant", 32'(sync_grant), 32'h0);
        reset_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
